// File: rtl/pcie_datalink_pkg.sv
// pcie_datalink_pkg: shared state type, class bit positions and lowest-class helper for the DLL receive path
package pcie_datalink_pkg;
    localparam int CLS_DLLP = 0;
    localparam int CLS_TLP  = 1;
    localparam int MAX_CH   = 8;

    typedef enum logic [1:0] {IDLE, FWD, DROP, FLUSH} rx_route_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } first_one_t;

    function automatic first_one_t first_one_idx(input logic [MAX_CH-1:0] user);
        first_one_t r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--)
            if (user[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        return r;
    endfunction
endpackage

// File: rtl/dllp_rx_ch_fifo.sv
// dllp_rx_ch_fifo: single-clock channel FIFO, output from registered storage, sync flush
module dllp_rx_ch_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             rd, wr;

    assign empty   = wp == rp;
    assign rd      = rd_en && !empty;
    // a read in the same cycle frees the slot, so a full FIFO still sustains one beat per cycle
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]) && !rd;
    assign wr      = wr_en && !full;
    assign rd_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(wr);
            rp <= rp + (AW+1)'(rd);
        end

    always_ff @(posedge clk_i)
        if (wr) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/dllp_rx_router.sv
// dllp_rx_router: routes ingress AXIS packets to NUM_CH per-class FIFOs by lowest tuser class bit
// Statistics counters exist only when DLLP_RX_ROUTER_STATS_EN is defined; otherwise they read 0.
module dllp_rx_router
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 4,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TLP_CH     = CLS_TLP,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         link_up_i,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    input  logic [USER_WIDTH-1:0]        s_axis_tuser,
    output logic                         s_axis_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_CH*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [NUM_CH*USER_WIDTH-1:0] m_axis_tuser,
    output logic [NUM_CH-1:0]            m_axis_tvalid,
    output logic [NUM_CH-1:0]            m_axis_tlast,
    input  logic [NUM_CH-1:0]            m_axis_tready,
    output logic                         first_tlp_valid_o,
    output logic [NUM_CH*CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]         drop_cnt_o
);
    localparam int CW = $clog2(NUM_CH);
    localparam int BW = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;

    rx_route_state_e   state_q, state_d;
    logic [CW-1:0]     route_q, ch;
    logic [MAX_CH-1:0] cls;
    first_one_t        sel;
    logic [NUM_CH-1:0] full, empty;
    logic              fwd, rdy, acc, wr, pkt_done, first_q;

    always_comb begin
        cls = '0;
        cls[NUM_CH-1:0] = s_axis_tuser[NUM_CH-1:0];
    end

    assign sel      = first_one_idx(cls);
    assign ch       = (state_q == IDLE) ? CW'(sel.idx) : route_q;
    assign fwd      = link_up_i && (state_q == FWD || (state_q == IDLE && sel.valid));
    assign rdy      = !fwd || !full[ch];
    assign acc      = s_axis_tvalid && rdy;
    assign wr       = fwd && acc;
    assign pkt_done = wr && s_axis_tlast;

    assign s_axis_tready     = rdy && rst_ni;
    assign first_tlp_valid_o = first_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (acc && !s_axis_tlast) state_d = sel.valid ? FWD : DROP;
            FWD, DROP: if (acc && s_axis_tlast) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (!link_up_i) state_d = FLUSH;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= IDLE;
            route_q <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= ch;
            first_q <= link_up_i && (first_q || (pkt_done && ch == CW'(TLP_CH)));
        end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BW-1:0] rd_data;
        dllp_rx_ch_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i,
            .rst_ni,
            .flush   (!link_up_i),
            .wr_en   (wr && ch == CW'(c)),
            .wr_data ({s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
            .rd_en   (m_axis_tready[c]),
            .rd_data (rd_data),
            .full    (full[c]),
            .empty   (empty[c])
        );
        assign {m_axis_tuser[c*USER_WIDTH +: USER_WIDTH], m_axis_tlast[c],
                m_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH], m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]} = rd_data;
        assign m_axis_tvalid[c] = !empty[c];
    end

`ifdef DLLP_RX_ROUTER_STATS_EN
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] pkt_q;
    logic [CNT_WIDTH-1:0]             drop_q;
    logic                             drop_inc;

    // a packet cut short by link-down is counted once, at the cycle the flush begins
    assign drop_inc = link_up_i ? (state_q == IDLE && !sel.valid && s_axis_tvalid) : (state_q == FWD);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (pkt_done && !(&pkt_q[ch])) pkt_q[ch] <= pkt_q[ch] + CNT_WIDTH'(1);
            if (drop_inc && !(&drop_q)) drop_q <= drop_q + CNT_WIDTH'(1);
        end

    assign pkt_cnt_o  = pkt_q;
    assign drop_cnt_o = drop_q;
`else
    assign pkt_cnt_o  = '0;
    assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dllp_rx_router.sv
// tb_dllp_rx_router: randomized scoreboard bench for dllp_rx_router against a queue-based reference model
module tb_dllp_rx_router;
    localparam int NC = 2, DW = 32, KW = 4, UW = 4, DEPTH = 4, TLP = 1, CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0, rst_n = 0, link_up = 1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic [UW-1:0] s_tuser = '0;
    logic s_tvalid = 0, s_tlast = 0, s_tready;
    logic [NC*DW-1:0] m_tdata;
    logic [NC*KW-1:0] m_tkeep;
    logic [NC*UW-1:0] m_tuser;
    logic [NC-1:0] m_tvalid, m_tlast;
    logic [NC-1:0] m_tready = '0;
    logic first_tlp;
    logic [NC*CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;
    logic [NC-1:0] rdy_mask = '1;
    bit rdy_rand = 0;
    int n_cmp = 0, n_err = 0;

    typedef logic [UW+KW+DW:0] beat_t;
    beat_t q[NC][$];
    int route = -1, m_drop = 0;
    int m_pkt[NC];
    bit in_pkt = 0, flushing = 0, m_first = 0;

    always #5 clk = ~clk;

    dllp_rx_router #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .NUM_CH(NC),
                     .FIFO_DEPTH(DEPTH), .TLP_CH(TLP), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .link_up_i(link_up),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .first_tlp_valid_o(first_tlp), .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [UW-1:0] u);
        for (int i = 0; i < NC; i++) if (u[i]) return i;
        return -1;
    endfunction

    function automatic int sat(input int v);
        return v < CMAX ? v + 1 : CMAX;
    endfunction

    function automatic int stat(input int v);
`ifdef DLLP_RX_ROUTER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    always @(posedge clk) begin
        #2;
        m_tready = (rdy_rand ? NC'($urandom) : NC'('1)) & rdy_mask;
    end

    // Monitor and reference model: outputs compared on the falling edge, model advanced for the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tvalid", m_tvalid, 0);
            chk("rst_tready", s_tready, 0);
            chk("rst_first", first_tlp, 0);
            chk("rst_pkt_cnt", pkt_cnt, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            for (int c = 0; c < NC; c++) begin q[c].delete(); m_pkt[c] = 0; end
            m_drop = 0; in_pkt = 0; flushing = 0; m_first = 0; route = -1;
        end else begin
            bit er, acc;
            int r;
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("tvalid%0d", c), m_tvalid[c], q[c].size() > 0);
                if (m_tvalid[c] && m_tready[c] && q[c].size() > 0)
                    chk($sformatf("beat%0d", c),
                        {m_tuser[c*UW +: UW], m_tlast[c], m_tkeep[c*KW +: KW], m_tdata[c*DW +: DW]},
                        q[c].pop_front());
                chk($sformatf("pkt_cnt%0d", c), pkt_cnt[c*CW +: CW], stat(m_pkt[c]));
            end
            chk("first_tlp", first_tlp, m_first);
            chk("drop_cnt", drop_cnt, stat(m_drop));
            if (!link_up || flushing) er = 1;
            else begin
                r = in_pkt ? route : lowest(s_tuser);
                er = (r < 0) || (q[r].size() < DEPTH);
            end
            chk("s_tready", s_tready, er);
            acc = s_tvalid && s_tready;
            if (!link_up) begin
                if (in_pkt && route >= 0) m_drop = sat(m_drop);
                for (int c = 0; c < NC; c++) q[c].delete();
                in_pkt = 0; m_first = 0; flushing = 1;
            end else if (flushing) flushing = 0;
            else if (acc) begin
                if (!in_pkt) begin
                    route = lowest(s_tuser);
                    if (route < 0) m_drop = sat(m_drop);
                end
                if (route >= 0) begin
                    q[route].push_back({s_tuser, s_tlast, s_tkeep, s_tdata});
                    if (s_tlast) begin
                        m_pkt[route] = sat(m_pkt[route]);
                        if (route == TLP) m_first = 1;
                    end
                end
                in_pkt = !s_tlast;
            end
        end
    end

    task automatic send_beat(input logic [UW-1:0] u, input logic [DW-1:0] d, input logic l);
        int n = 0;
        s_tvalid = 1; s_tuser = u; s_tdata = d; s_tlast = l; s_tkeep = KW'($urandom);
        @(negedge clk);
        while (!s_tready && n < 300) begin @(negedge clk); n++; end
        if (!s_tready) begin
            n_cmp++; n_err++;
            $display("FAIL ingress_timeout: s_tready 0 for 300 cycles, required 1");
        end
        @(posedge clk); #1;
        s_tvalid = 0; s_tlast = 0; s_tuser = '0;
    endtask

    task automatic send_pkt(input logic [UW-1:0] u, input int len, input logic [DW-1:0] base, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            send_beat(u, base + DW'(i), i == len - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q[0].size() + q[1].size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        if (q[0].size() + q[1].size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", q[0].size() + q[1].size());
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        send_pkt(4'b0010, 3, 32'hA0, 0);
        drain();
        chk("first_tlp_after_tlp", first_tlp, 1);
        send_pkt(4'b0011, 2, 32'hB0, 0);
        send_pkt(4'b0000, 2, 32'hC0, 0);
        drain();
        rdy_mask = 2'b00;
        send_pkt(4'b0001, 2, 32'hD0, 0);
        rdy_mask = 2'b01;
        fork
            begin send_pkt(4'b0010, 6, 32'hE0, 0); send_pkt(4'b0001, 1, 32'hF0, 0); end
            begin repeat (20) @(posedge clk); #1 rdy_mask = 2'b11; end
        join
        drain();
        rdy_mask = 2'b00;
        send_beat(4'b0010, 32'h10, 0);
        send_beat(4'b0010, 32'h11, 0);
        s_tvalid = 1; s_tdata = 32'h12; s_tuser = 4'b0010; link_up = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("flush_first", first_tlp, 0);
        chk("flush_tvalid", m_tvalid, 0);
        s_tvalid = 0; s_tuser = '0; link_up = 1; rdy_mask = 2'b11;
        repeat (2) begin @(posedge clk); #1; end
        send_pkt(4'b0010, 1, 32'h20, 0);
        drain();
        rdy_rand = 1;
        repeat (40) send_pkt(UW'($urandom), $urandom_range(1, 5), $urandom, 1);
        drain();
        rdy_rand = 0;
        repeat (18) send_pkt(4'b0001, 1, $urandom, 0);
        repeat (17) send_pkt(4'b0100, 1, $urandom, 0);
        drain();
        send_beat(4'b0010, 32'h30, 0);
        s_tvalid = 1; s_tdata = 32'h31; s_tuser = 4'b0010;
        #2 rst_n = 0;
        #1;
        chk("async_rst_tready", s_tready, 0);
        chk("async_rst_tvalid", m_tvalid, 0);
        chk("async_rst_first", first_tlp, 0);
        chk("async_rst_pkt_cnt", pkt_cnt, 0);
        chk("async_rst_drop_cnt", drop_cnt, 0);
        s_tvalid = 0; s_tuser = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        send_pkt(4'b0010, 2, 32'h40, 0);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
